// File: rtl/c7_seq_divider_if.sv
// Operand/result bundle for the sequential restoring divider.
// The tile wrapper (or a bench) drives the master side; the divider is the slave.
interface c7_seq_divider_if #(
  parameter int N_W = 8,
  parameter int D_W = 4
);
  logic           start;
  logic [N_W-1:0] dividend;
  logic [D_W-1:0] divisor;
  logic           busy;
  logic           done;
  logic [N_W-1:0] quotient;
  logic [D_W-1:0] remainder;
  logic           div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/c7_seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// start/busy/done handshake; results are held until the next accepted start.
module c7_seq_divider #(
  parameter int N_W = 8,
  parameter int D_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  c7_seq_divider_if.slave   bus
);

  localparam int CNT_W = (N_W > 1) ? $clog2(N_W + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [N_W-1:0]   r_dvd_sh;     // dividend shifting out at the top, quotient bits in at the bottom
  logic [D_W-1:0]   r_dvs;        // latched divisor
  logic [D_W:0]     r_prem;       // partial remainder, one bit wider than the divisor
  logic [CNT_W-1:0] r_cnt;        // iterations completed in the current operation

  logic [N_W-1:0]   r_quot;
  logic [D_W-1:0]   r_rem;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic             w_dvs_zero;
  logic [D_W+1:0]   w_shifted;    // partial remainder after pulling in the next dividend bit
  logic [D_W+1:0]   w_trial;      // trial subtraction; MSB is the borrow
  logic             w_neg;
  logic [D_W:0]     w_prem_nxt;
  logic [N_W-1:0]   w_dvd_nxt;
  logic             w_busy;
  logic             w_done;

  // Handshake decode: a start only counts in IDLE, and the final iteration is flagged by the counter.
  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_dvs_zero = (bus.divisor == '0);
  assign w_last     = (r_state == S_RUN) && (r_cnt == CNT_W'(N_W - 1));

  // One restoring step: shift, trial-subtract, keep the difference only if it did not borrow.
  // The shifted value is always below twice the divisor, so a D_W+2 bit subtraction cannot wrap.
  assign w_shifted  = {r_prem, r_dvd_sh[N_W-1]};
  assign w_trial    = w_shifted - {2'b00, r_dvs};
  assign w_neg      = w_trial[D_W+1];
  assign w_prem_nxt = w_neg ? w_shifted[D_W:0] : w_trial[D_W:0];

  generate
    if (N_W > 1) begin : g_shift_wide
      assign w_dvd_nxt = {r_dvd_sh[N_W-2:0], ~w_neg};
    end else begin : g_shift_single
      assign w_dvd_nxt = ~w_neg;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every flop
    // samples the values from before the edge, independent of process ordering.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN (or straight to DONE on a zero divisor), RUN -> DONE after N_W steps.
  always_comb begin
    // NOTE: default first, so every path assigns the variable and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = w_dvs_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: busy for the whole RUN state, done for the single DONE cycle.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Iteration state and visible results; results change only on the accepting or final edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_prem <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_prem <= '0;
      if (w_dvs_zero) begin
        r_quot <= '1;
        r_rem  <= '0;
        r_dbz  <= 1'b1;
      end else begin
        r_dbz  <= 1'b0;
      end
    end else if (r_state == S_RUN) begin
      r_prem <= w_prem_nxt;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_quot <= w_dvd_nxt;
        r_rem  <= w_prem_nxt[D_W-1:0];
      end
    end
  end

  // Operand registers: loaded on accept, dividend register shifts during RUN.
  always_ff @(posedge clk) begin
    // NOTE: these carry no reset; they are always loaded on the accepting edge
    // before anything reads them, so a reset would only add fan-out.
    if (w_accept) begin
      r_dvd_sh <= bus.dividend;
      r_dvs    <= bus.divisor;
    end else if (r_state == S_RUN) begin
      r_dvd_sh <= w_dvd_nxt;
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_c7_seq_divider.sv
// Self-checking bench for c7_seq_divider: directed cases with literal answers,
// then an exhaustive operand sweep with random disturbance, all checked every
// cycle against an arithmetic reference model.
module tb_c7_seq_divider;

  localparam int N_W = 8;
  localparam int D_W = 4;

  logic clk = 1'b0;
  logic rst;

  c7_seq_divider_if #(.N_W(N_W), .D_W(D_W)) dif ();

  c7_seq_divider #(.N_W(N_W), .D_W(D_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: cycles remaining until the result, plus the result itself from / and %.
  int           m_left     = 0;
  bit           m_done     = 1'b0;
  bit [N_W-1:0] m_q        = '0;
  bit [D_W-1:0] m_r        = '0;
  bit           m_z        = 1'b0;
  bit [N_W-1:0] p_q        = '0;
  bit [D_W-1:0] p_r        = '0;
  int           p_a        = 0;
  int           p_b        = 0;
  int           m_done_cnt = 0;
  int           dut_done_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_q    = '0;
      m_r    = '0;
      m_z    = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_done_cnt++;
        m_q = p_q;
        m_r = p_r;
      end
    end else if (dif.start === 1'b1) begin
      p_a = int'(dif.dividend);
      p_b = int'(dif.divisor);
      if (p_b == 0) begin
        m_done = 1'b1;
        m_done_cnt++;
        m_q = '1;
        m_r = '0;
        m_z = 1'b1;
      end else begin
        m_left = N_W;
        m_z    = 1'b0;
        p_q    = N_W'(p_a / p_b);
        p_r    = D_W'(p_a % p_b);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",        dif.busy,        m_left > 0);
      check("done",        dif.done,        m_done);
      check("quotient",    dif.quotient,    m_q);
      check("remainder",   dif.remainder,   m_r);
      check("div_by_zero", dif.div_by_zero, m_z);
      if (dif.done === 1'b1) dut_done_cnt++;
      if (m_done && !m_z) begin
        check("invariant",  int'(dif.quotient) * p_b + int'(dif.remainder), p_a);
        check("rem_lt_div", int'(dif.remainder) < p_b, 1);
      end
    end
  end

  // One operation from IDLE through DONE; optional stray start (50/5) at cycle inj.
  task automatic do_op(input int a, input int b, input int eq, input int er,
                       input bit ez, input int inj);
    int lat;
    int busy_n;
    logic [N_W-1:0] prev_q;
    logic [D_W-1:0] prev_r;
    lat    = 0;
    busy_n = 0;
    prev_q = dif.quotient;
    prev_r = dif.remainder;
    dif.start    = 1'b1;
    dif.dividend = N_W'(a);
    dif.divisor  = D_W'(b);
    do begin
      @(negedge clk);
      lat++;
      dif.start = (inj != 0 && lat == inj);
      if (inj != 0 && lat == inj) begin
        dif.dividend = N_W'(50);
        dif.divisor  = D_W'(5);
      end
      if (dif.busy === 1'b1) begin
        busy_n++;
        check("hold_q", dif.quotient, prev_q);
        check("hold_r", dif.remainder, prev_r);
      end
    end while (dif.done !== 1'b1 && lat < 40);
    check("done_seen",   dif.done, 1);
    check("latency",     lat, ez ? 1 : N_W + 1);
    check("busy_cycles", busy_n, ez ? 0 : N_W);
    check("lit_q",       dif.quotient, eq);
    check("lit_r",       dif.remainder, er);
    check("lit_z",       dif.div_by_zero, ez);
    check("model_q",     m_q, eq);
    check("model_r",     m_r, er);
    dif.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int dn;
    int cyc;
    int first;
    int second;
    int n;

    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", dif.busy, 0);
    check("rst_done", dif.done, 0);
    check("rst_q",    dif.quotient, 0);
    check("rst_r",    dif.remainder, 0);
    check("rst_z",    dif.div_by_zero, 0);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(200, 13, 15,  5, 1'b0, 0);
    do_op(7,    9,  0,  7, 1'b0, 0);
    do_op(255,  1, 255, 0, 1'b0, 0);
    do_op(225, 15, 15,  0, 1'b0, 0);
    do_op(8'h5A, 0, 8'hFF, 0, 1'b1, 0);
    do_op(12,   4,  3,  0, 1'b0, 0);
    do_op(100,  7, 14,  2, 1'b0, 3);

    // Reset in the middle of a run: outputs clear and no done follows.
    dif.start    = 1'b1;
    dif.dividend = N_W'(200);
    dif.divisor  = D_W'(13);
    @(negedge clk);
    dif.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", dif.busy, 0);
    check("midrst_done", dif.done, 0);
    check("midrst_q",    dif.quotient, 0);
    check("midrst_r",    dif.remainder, 0);
    check("midrst_z",    dif.div_by_zero, 0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (dif.done === 1'b1) dn++;
    end
    check("no_done_after_rst", dn, 0);
    do_op(9, 2, 4, 1, 1'b0, 0);

    // start held high: back-to-back operations every N_W+2 cycles.
    dif.start    = 1'b1;
    dif.dividend = N_W'(225);
    dif.divisor  = D_W'(15);
    cyc    = 0;
    first  = -1;
    second = -1;
    while (cyc < 60 && second < 0) begin
      @(negedge clk);
      cyc++;
      if (dif.done === 1'b1) begin
        if (first < 0) first = cyc;
        else           second = cyc;
      end
    end
    dif.start = 1'b0;
    check("throughput", second - first, N_W + 2);
    @(negedge clk);

    // Exhaustive operand sweep with random operand/start noise while busy or done.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = N_W'(a);
        dif.divisor  = D_W'(b);
        @(negedge clk);
        dif.start = 1'b0;
        n = 0;
        while ((dif.busy === 1'b1 || dif.done === 1'b1) && n < 30) begin
          dif.dividend = N_W'($urandom);
          dif.divisor  = D_W'($urandom);
          dif.start    = 1'($urandom_range(0, 1));
          @(negedge clk);
          n++;
        end
        dif.start = 1'b0;
        check("sweep_bound", n < 30, 1);
      end
    end

    @(negedge clk);
    check("done_count", dut_done_cnt, m_done_cnt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
